// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM; memory states stretch by MEM_WAIT cycles.
// Optional: define MC_MAINDEC_TRAP_EN to trap unsupported opcodes in a HALT state.
module mc_maindec #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MC_MAINDEC_TRAP_EN
    S_JEX     = 4'd11,
    S_HALT    = 4'd15
`else
    S_JEX     = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(MEM_WAIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q;
  logic             op_ok;

  function automatic ctrl_t decode(input state_t s, input logic last);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = last;
        c.pcwrite = last;
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH:
        if (cnt_q != WAIT_C) cnt_d = cnt_q + 1'b1;
        else                 state_d = S_DECODE;
      S_DECODE:
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_MAINDEC_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (cnt_q != WAIT_C) cnt_d = cnt_q + 1'b1;
        else                 state_d = S_MEMWB;
      S_MEMWR:
        if (cnt_q != WAIT_C) cnt_d = cnt_q + 1'b1;
        else                 state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
`ifdef MC_MAINDEC_TRAP_EN
      S_HALT:    state_d = S_HALT;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state/counter so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ctrl_q  <= decode(S_FETCH, WAIT_C == '0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode(state_d, cnt_d == WAIT_C);
    end
  end

  always_comb begin
    illegal_op = (state_q == S_DECODE) && !op_ok;
`ifdef MC_MAINDEC_TRAP_EN
    if (state_q == S_HALT) illegal_op = 1'b1;
`endif
  end

  assign state    = state_q;
  assign memwrite = ctrl_q.memwrite;
  assign irwrite  = ctrl_q.irwrite;
  assign pcwrite  = ctrl_q.pcwrite;
  assign branch   = ctrl_q.branch;
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign regwrite = ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-instruction expected state/output sequences plus cycle-count pins.
module tb_mc_maindec;

  localparam int W = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       memwrite, irwrite, pcwrite, branch, iord, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;
  logic       illegal_op;

  mc_maindec #(.MEM_WAIT(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op),
    .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct { int st; bit last; } ent_t;
  ent_t seq[$];
  int errors = 0;
  int checks = 0;

  function automatic bit legal(input logic [5:0] o);
    return o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 || o == 6'h08 || o == 6'h02;
  endfunction

  // {memwrite,irwrite,pcwrite,branch,iord,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsrc,aluop}
  function automatic logic [14:0] exp_ctrl(input int st, input bit last);
    logic mw = 0, ir = 0, pw = 0, br = 0, io = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, ps = 0, ao = 0;
    case (st)
      0:  begin sb = 1; ir = last; pw = last; end
      1:  sb = 3;
      2, 9: begin sa = 1; sb = 2; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; ao = 2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; ao = 1; ps = 1; br = 1; end
      10: rw = 1;
      11: begin ps = 2; pw = 1; end
      default: ;
    endcase
    return {mw, ir, pw, br, io, m2r, rd, rw, sa, sb, ps, ao};
  endfunction

  task automatic push(input int st, input bit mem);
    if (mem) for (int j = 0; j <= W; j++) seq.push_back('{st, j == W});
    else seq.push_back('{st, 1'b1});
  endtask

  task automatic build(input logic [5:0] o);
    seq.delete();
    push(0, 1); push(1, 0);
    case (o)
      6'h23: begin push(2, 0); push(3, 1); push(4, 0); end
      6'h2b: begin push(2, 0); push(5, 1); end
      6'h00: begin push(6, 0); push(7, 0); end
      6'h04: push(8, 0);
      6'h08: begin push(9, 0); push(10, 0); end
      6'h02: push(11, 0);
      default: begin
`ifdef MC_MAINDEC_TRAP_EN
        for (int j = 0; j < 4; j++) push(15, 0);
`endif
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_ent(input ent_t e);
    bit ill;
    ill = (e.st == 15) || (e.st == 1 && !legal(op));
    check("state", 32'(state), 32'(e.st));
    check("ctrl", 32'({memwrite, irwrite, pcwrite, branch, iord, memtoreg, regdst, regwrite,
                      alusrca, alusrcb, pcsrc, aluop}), 32'(exp_ctrl(e.st, e.last)));
    check("illegal_op", 32'(illegal_op), 32'(ill));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Run one instruction from FETCH; rst_at >= 0 asserts reset right after that entry.
  task automatic run_instr(input logic [5:0] o, input int rst_at);
    int ra;
    op = o;
    build(o);
    ra = rst_at;
`ifdef MC_MAINDEC_TRAP_EN
    if (!legal(o)) ra = seq.size() - 1;
`endif
    for (int i = 0; i < seq.size(); i++) begin
      check_ent(seq[i]);
      if (i == ra) begin
        do_reset();
        return;
      end
      tick();
    end
  endtask

  task automatic measure(input string nm, input logic [5:0] o, input int exp_len);
    int c;
    bit seen;
    c = 0;
    seen = 0;
    op = o;
    for (int i = 0; i < 64; i++) begin
      tick();
      c++;
      if (state != 4'd0) seen = 1;
      else if (seen) break;
    end
    check(nm, 32'(c), 32'(exp_len));
  endtask

  initial begin
    logic [5:0] ro;
    int rsel;
    tick();
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_irwrite", 32'(irwrite), 32'd0);
    run_instr(6'h23, -1);
    run_instr(6'h2b, -1);
    run_instr(6'h00, -1);
    run_instr(6'h04, -1);
    run_instr(6'h02, -1);
    run_instr(6'h08, -1);
    run_instr(6'h3f, -1);
    // LW: FETCH(W+1), DECODE, MEMADR, then 2nd MEMRD cycle is entry W+4.
    run_instr(6'h23, W + 4);
    check("rst_mid_state", 32'(state), 32'd0);
    run_instr(6'h00, -1);
    measure("len_lw", 6'h23, 9);
    measure("len_sw", 6'h2b, 8);
    measure("len_rtype", 6'h00, 6);
    measure("len_addi", 6'h08, 6);
    measure("len_beq", 6'h04, 5);
    measure("len_j", 6'h02, 5);
    for (int n = 0; n < 80; n++) begin
      rsel = int'($urandom_range(0, 7));
      case (rsel)
        0: ro = 6'h23;
        1: ro = 6'h2b;
        2: ro = 6'h00;
        3: ro = 6'h04;
        4: ro = 6'h08;
        5: ro = 6'h02;
        default: begin
          ro = 6'($urandom);
          if (legal(ro)) ro = 6'h3f;
        end
      endcase
      build(ro);
      if ($urandom_range(0, 9) == 0) run_instr(ro, int'($urandom_range(0, seq.size() - 1)));
      else run_instr(ro, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_maindec.md
Name: mc_maindec

Overview:
Multicycle main control FSM for the MIPS core. It is the sequential successor to the single-cycle opcode decoder. It steps each instruction through FETCH/DECODE/execute/writeback states and drives datapath enables per state (Moore outputs). Memory states stretch by a parametrised wait count so slow instruction/data memory can be used without datapath changes.

Parameters:
MEM_WAIT, 0, extra wait cycles spent in each memory-access state (FETCH, MEMRD, MEMWR); legal 0..15
CNT_W, 4, width of the internal wait counter; must hold MEM_WAIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  opcode from instruction register, stable from DECODE to end of instruction
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load
pcwrite  output  1  unconditional PC load
branch  output  1  conditional PC load (datapath ANDs with zero)
iord  output  1  0 = PC addresses memory, 1 = ALUOut
memtoreg  output  1  register writeback select (1 = memory data)
regdst  output  1  1 = rd, 0 = rt destination
regwrite  output  1  register file write enable
alusrca  output  1  0 = PC, 1 = reg A
alusrcb  output  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded
state  output  4  current state code (debug/verification)
illegal_op  output  1  unsupported opcode flag

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. With `reset` high at an edge: state <= FETCH (0) and wait counter <= 0. `reset` overrides all transitions, including mid memory wait.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, HALT=15 (HALT exists only with the optional feature).
- Outputs are decoded from state and counter only. Any output not listed for a state is 0.
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=1 and pcwrite=1 only on the final FETCH cycle (counter==MEM_WAIT).
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1 on every cycle of the state.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE
  - DECODE on op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH.
  - MEMADR: op=100011 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
- Wait counter: in FETCH, MEMRD and MEMWR the FSM holds while counter < MEM_WAIT, incrementing by 1 per cycle. It leaves when counter == MEM_WAIT, clearing the counter on exit. The counter is 0 in all other states. With MEM_WAIT=0 each state lasts exactly 1 cycle.
- Instruction cycle counts (W=MEM_WAIT): LW 5+2W, SW 4+2W, R-type 4+W, ADDI 4+W, BEQ 3+W, J 3+W.
- illegal_op: combinational, 1 while state==DECODE and op is unsupported; 0 otherwise.

Optional Feature:
MC_MAINDEC_TRAP_EN
- Defined: an unsupported op in DECODE goes to HALT instead of FETCH. In HALT all control outputs are 0, state=15 and illegal_op=1 continuously. HALT is exited only by `reset`.
- Undefined: no HALT state. An unsupported op skips back to FETCH and illegal_op pulses for the single DECODE cycle.

Test Plan:
- MEM_WAIT=0, reset then op=100011: state sequence 0,1,2,3,4,0 over 5 cycles; regwrite=1 and memtoreg=1 only in state 4; irwrite=1 in cycle 1 only.
- MEM_WAIT=2, op=101011: FETCH lasts 3 cycles with irwrite/pcwrite high only in the 3rd; MEMWR lasts 3 cycles with memwrite=1 throughout; total 8 cycles back to FETCH.
- MEM_WAIT=0, op=000000 then 000100 then 000010: RTYPEEX aluop=10 then RTYPEWB regdst=1; BEQEX aluop=01, branch=1, pcsrc=01; JEX pcwrite=1, pcsrc=10; total 4+3+3 cycles.
- op=001000: ADDIEX alusrcb=10; then ADDIWB regwrite=1, regdst=0, memtoreg=0.
- op=111111, macro undefined: illegal_op=1 for one cycle in state 1, next state 0. Macro defined: state goes to 15 and holds with illegal_op=1 until reset, then state=0.
- MEM_WAIT=3: assert reset during the 2nd MEMRD cycle -> next state=0 with counter 0; the following FETCH lasts exactly 4 cycles.
